// File: rtl/if_pkg.sv
// Shared types and constants for the miniRV instruction fetch stage.
package if_pkg;

    localparam int          IF_ADDR_W   = 32;
    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } if_state_e;

    typedef struct packed {
        logic [31:0]          inst;
        logic [IF_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_inst_fifo.sv
// Small synchronous FIFO with first-word fall-through output and a flush.
module if_inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop)  rd_q <= rd_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the fetch PC, talks req/gnt/rvalid to instruction memory,
// buffers responses in order and hands {inst, pc, pc+4} to decode.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W     = IF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(IF_RESET_PC),
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc4
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [ADDR_W-1:0] pc_hold_q, pc_hold_d;

    logic [ADDR_W-1:0]    tag_dout;
    logic [CNT_W-1:0]     tag_count;
    logic                 tag_full, tag_empty;
    logic [ADDR_W+31:0]   dat_dout;
    logic [CNT_W-1:0]     dat_count;
    logic                 dat_full, dat_empty;

    logic              gnt_ok, live_rsp, drop_rsp, rsp_any, id_fire;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W:0]    occ;

    assign id_valid = !dat_empty;
    assign id_fire  = id_valid && id_ready;
    assign inflight = tag_count + drop_q;

    // Counting the decode pop frees its slot for a new request this cycle,
    // which is what lets zero-wait memory stream one word per cycle.
    assign occ      = {1'b0, tag_count} + {1'b0, dat_count} - (CNT_W+1)'(id_fire);
    assign imem_req = (state_q == S_RUN) && (occ < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_addr = fpc_q;

    assign gnt_ok   = imem_req && imem_gnt;
    // Stale responses (drop_q != 0) are always older than any tagged request.
    assign drop_rsp = imem_rvalid && (drop_q != '0);
    assign live_rsp = imem_rvalid && (drop_q == '0) && !tag_empty;
    assign rsp_any  = drop_rsp || live_rsp;

    assign id_inst = id_valid ? dat_dout[ADDR_W+31:ADDR_W] : NOP_INST;
    assign id_pc   = id_valid ? dat_dout[ADDR_W-1:0] : pc_hold_q;
    assign id_pc4  = id_pc + ADDR_W'(4);

    if_inst_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (gnt_ok),
        .pop   (live_rsp),
        .flush (redirect),
        .din   (fpc_q),
        .dout  (tag_dout),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    if_inst_fifo #(.WIDTH(ADDR_W + 32), .DEPTH(FIFO_DEPTH)) u_inst_q (
        .clk   (clk),
        .rst   (rst),
        .push  (live_rsp),
        .pop   (id_fire),
        .flush (redirect),
        .din   ({imem_rdata, tag_dout}),
        .dout  (dat_dout),
        .count (dat_count),
        .full  (dat_full),
        .empty (dat_empty)
    );

    always_comb begin
        state_d   = state_q;
        fpc_d     = fpc_q;
        drop_d    = drop_q;
        pc_hold_d = id_valid ? dat_dout[ADDR_W-1:0] : pc_hold_q;
        if (gnt_ok) fpc_d = fpc_q + ADDR_W'(4);
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            S_FLUSH: begin
                if (drop_rsp) drop_d = drop_q - CNT_W'(1);
                if (drop_d == '0) state_d = S_RUN;
            end
            default: state_d = S_BOOT;
        endcase
        // Everything still in flight after this cycle becomes stale.
        if (redirect) begin
            fpc_d   = {redirect_pc[ADDR_W-1:2], 2'b00};
            drop_d  = inflight + CNT_W'(gnt_ok) - CNT_W'(rsp_any);
            state_d = (drop_d != '0) ? S_FLUSH : S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_BOOT;
            fpc_q     <= RESET_PC;
            drop_q    <= '0;
            pc_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            drop_q    <= drop_d;
            pc_hold_q <= pc_hold_d;
        end
    end

    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (!tag_empty || drop_q != '0));
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(gnt_ok && tag_full && !live_rsp));
    a_buf_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(live_rsp && dat_full && !id_fire));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized scoreboard bench for if_fetch_unit: memory model, program-order
// reference stream, and directed checks for latency, backpressure, redirect, wrap, reset.
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect, id_valid, id_ready;
    logic [31:0] redirect_pc, id_inst, id_pc, id_pc4;

    int total = 0, bad = 0, nfire = 0, gcount = 0, cyc = 0;
    int gnt_pct = 100, dmin = 1, dmax = 1;
    logic [31:0]  pend_addr[$];
    int           pend_rdy[$];
    fetch_entry_t expq[$];
    logic [31:0]  gen_pc = RPC;

    if_fetch_unit #(.ADDR_W(32), .RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0BAD_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic refill();
        fetch_entry_t e;
        while (expq.size() < 8) begin
            e.inst = mem_word(gen_pc);
            e.pc   = gen_pc;
            expq.push_back(e);
            gen_pc += 32'd4;
        end
    endtask

    // Memory: random grant, in-order responses after a configurable delay.
    initial begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            imem_gnt = ($urandom_range(99) < gnt_pct);
            if (pend_addr.size() > 0 && pend_rdy[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr.pop_front());
                void'(pend_rdy.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_addr.delete(); pend_rdy.delete(); gcount = 0;
            end else if (imem_req && imem_gnt) begin
                pend_addr.push_back(imem_addr);
                pend_rdy.push_back(cyc + $urandom_range(dmax, dmin));
                gcount++;
            end
        end
    end

    // Scoreboard monitor: decode must see the program-order stream.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                expq.delete(); gen_pc = RPC;
            end else begin
                chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
                if (id_valid && id_ready) begin
                    nfire++;
                    if (expq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL sb_empty: got pc %h want nothing", id_pc);
                    end else begin
                        e = expq.pop_front();
                        chk("id_pc",   id_pc,   e.pc);
                        chk("id_inst", id_inst, e.inst);
                        chk("id_pc4",  id_pc4,  e.pc + 32'd4);
                    end
                end else if (!id_valid) begin
                    chk("idle_nop", id_inst, NOP_INST);
                end
                if (redirect) begin
                    expq.delete();
                    gen_pc = {redirect_pc[31:2], 2'b00};
                end
            end
            refill();
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; redirect = 1'b0; id_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req",   imem_req,  32'd0);
        chk("rst_addr",  imem_addr, RPC);
        chk("rst_vld",   id_valid,  32'd0);
        chk("rst_inst",  id_inst,   NOP_INST);
        chk("rst_pc",    id_pc,     32'd0);
        chk("rst_pc4",   id_pc4,    32'd4);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic redirect_check(input logic [31:0] tgt);
        logic [31:0] al;
        bit seen;
        al = {tgt[31:2], 2'b00};
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = tgt;
        @(posedge clk); #1;
        redirect = 1'b0; redirect_pc = $urandom();
        @(negedge clk);
        chk("redir_vld_clr", id_valid,  32'd0);
        chk("redir_addr",    imem_addr, al);
        chk("redir_noreq",   imem_req,  32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (id_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("redir_seen", seen, 32'd1);
        if (seen) begin
            chk("redir_pc",  id_pc,  al);
            chk("redir_pc4", id_pc4, al + 32'd4);
        end
    endtask

    initial begin
        int n0;
        redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;

        // Zero-wait streaming and first-instruction latency.
        gnt_pct = 100; dmin = 1; dmax = 1;
        do_reset();
        id_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            chk("lat_vld", id_valid, 32'(n >= 3));
        end

        // Decode stall fills the buffer and stops requests.
        do_reset();
        for (int n = 0; n < 10; n++) @(negedge clk);
        chk("bp_req",    imem_req, 32'd0);
        chk("bp_grants", gcount,   32'd2);
        chk("bp_vld",    id_valid, 32'd1);
        chk("bp_pc",     id_pc,    32'd0);
        @(posedge clk); #1;
        id_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("bp_stream", id_valid, 32'd1);
        end

        // Redirect with slow responses in flight.
        dmin = 3; dmax = 3;
        do_reset();
        id_ready = 1'b1;
        repeat (8) @(posedge clk);
        redirect_check(32'h0000_0200);
        repeat (6) @(posedge clk);

        // Redirect coinciding with grant and response, then wrap-around.
        dmin = 1; dmax = 1;
        do_reset();
        id_ready = 1'b1;
        repeat (10) @(posedge clk);
        redirect_check(32'h0000_0040);
        repeat (4) @(posedge clk);
        redirect_check(32'hFFFF_FFFE);
        repeat (8) @(posedge clk);

        // Reset with a full buffer.
        #1 id_ready = 1'b0;
        for (int n = 0; n < 10; n++) @(negedge clk);
        chk("pre_rst_vld", id_valid, 32'd1);
        chk("pre_rst_req", imem_req, 32'd0);
        do_reset();

        // Randomized traffic.
        n0 = nfire;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (c % 500 == 0) begin
                gnt_pct = $urandom_range(100, 30);
                dmin    = 1;
                dmax    = $urandom_range(5, 1);
            end
            rst = 1'b0; redirect = 1'b0;
            case ($urandom_range(999)) inside
                [0:2]:  rst = 1'b1;
                [3:34]: begin redirect = 1'b1; redirect_pc = $urandom(); end
                default: ;
            endcase
            id_ready = ($urandom_range(99) < 70);
        end
        @(posedge clk); #1;
        rst = 1'b0; redirect = 1'b0; id_ready = 1'b1;
        repeat (20) @(posedge clk);
        chk("rand_progress", 32'((nfire - n0) > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
